// File: rtl/res_pack.sv
// ------------------------------------------------------------------------
// res_pack : packs NUM result bytes LSB-first into one valid/ready package
// Revision : 1.0
// ------------------------------------------------------------------------
`default_nettype none

module res_pack #(
  parameter int NUM           = 100,
  parameter int DATA_W        = 8,
  parameter int PACKAGE_WIDTH = NUM * DATA_W,
  parameter int LEN_W         = $clog2(NUM + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     flush,
  output logic                     pkt_valid,
  input  logic                     pkt_ready,
  output logic [PACKAGE_WIDTH-1:0] pkt_data,
  output logic [LEN_W-1:0]         pkt_len,
  output logic [15:0]              pkt_sum,
  output logic [15:0]              pkt_count,
  output logic [15:0]              drop_count,
  output logic                     overflow
);

  localparam int IDX_W = $clog2(NUM);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t                   state_q,      state_d;
  logic [IDX_W-1:0]         idx_q,        idx_d;
  logic [PACKAGE_WIDTH-1:0] buf_q,        buf_d;
  logic [15:0]              sum_q,        sum_d;
  logic                     pkt_valid_q,  pkt_valid_d;
  logic [LEN_W-1:0]         pkt_len_q,    pkt_len_d;
  logic [15:0]              pkt_sum_q,    pkt_sum_d;
  logic [15:0]              pkt_count_q,  pkt_count_d;
  logic [15:0]              drop_count_q, drop_count_d;
  logic                     overflow_q,   overflow_d;

  logic [15:0]              in_ext;
  logic [15:0]              sum_next;
  logic                     last_beat;
  logic                     do_flush;

  assign in_ext = 16'(in_data);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    buf_d        = buf_q;
    sum_d        = sum_q;
    pkt_valid_d  = pkt_valid_q;
    pkt_len_d    = pkt_len_q;
    pkt_sum_d    = pkt_sum_q;
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;
    overflow_d   = overflow_q;
    sum_next     = sum_q + (in_valid ? in_ext : 16'd0);
    last_beat    = in_valid && (idx_q == IDX_W'(NUM - 1));
    do_flush     = flush && ((idx_q != '0) || in_valid);

    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          buf_d[int'(idx_q)*DATA_W +: DATA_W] = in_data;
          sum_d = sum_next;
          idx_d = idx_q + IDX_W'(1);
        end
        if (last_beat || do_flush) begin
          state_d     = HOLD;
          pkt_valid_d = 1'b1;
          pkt_len_d   = LEN_W'(idx_q) + LEN_W'(in_valid);
          pkt_sum_d   = sum_next;
        end
      end
      HOLD: begin
        if (pkt_ready) begin
          // Next package starts from a zeroed buffer; a beat in the
          // handshake cycle becomes its result 0.
          state_d     = COLLECT;
          pkt_valid_d = 1'b0;
          pkt_count_d = pkt_count_q + 16'd1;
          buf_d       = '0;
          idx_d       = '0;
          sum_d       = 16'd0;
          if (in_valid) begin
            buf_d[DATA_W-1:0] = in_data;
            idx_d             = IDX_W'(1);
            sum_d             = in_ext;
          end
        end else if (in_valid) begin
          overflow_d = 1'b1;
          if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= COLLECT;
      idx_q        <= '0;
      buf_q        <= '0;
      sum_q        <= 16'd0;
      pkt_valid_q  <= 1'b0;
      pkt_len_q    <= '0;
      pkt_sum_q    <= 16'd0;
      pkt_count_q  <= 16'd0;
      drop_count_q <= 16'd0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      buf_q        <= buf_d;
      sum_q        <= sum_d;
      pkt_valid_q  <= pkt_valid_d;
      pkt_len_q    <= pkt_len_d;
      pkt_sum_q    <= pkt_sum_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign pkt_valid  = pkt_valid_q;
  assign pkt_data   = buf_q;
  assign pkt_len    = pkt_len_q;
  assign pkt_sum    = pkt_sum_q;
  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;
  assign overflow   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_res_pack.sv
// ------------------------------------------------------------------------
// tb_res_pack : directed scoreboard bench for res_pack (NUM=4 and NUM=100)
// Revision    : 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_res_pack;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Small instance
  logic        a_in_valid = 1'b0;
  logic [7:0]  a_in_data  = 8'h00;
  logic        a_flush    = 1'b0;
  logic        a_pkt_valid;
  logic        a_pkt_ready = 1'b1;
  logic [31:0] a_pkt_data;
  logic [2:0]  a_pkt_len;
  logic [15:0] a_pkt_sum, a_pkt_count, a_drop_count;
  logic        a_overflow;

  // Full-size instance
  logic         b_in_valid = 1'b0;
  logic [7:0]   b_in_data  = 8'h00;
  logic         b_flush    = 1'b0;
  logic         b_pkt_valid;
  logic         b_pkt_ready = 1'b1;
  logic [799:0] b_pkt_data;
  logic [6:0]   b_pkt_len;
  logic [15:0]  b_pkt_sum, b_pkt_count, b_drop_count;
  logic         b_overflow;

  res_pack #(.NUM(4)) u_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_data(a_in_data),
    .flush(a_flush), .pkt_valid(a_pkt_valid), .pkt_ready(a_pkt_ready),
    .pkt_data(a_pkt_data), .pkt_len(a_pkt_len), .pkt_sum(a_pkt_sum),
    .pkt_count(a_pkt_count), .drop_count(a_drop_count), .overflow(a_overflow)
  );

  res_pack #(.NUM(100)) u_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_data(b_in_data),
    .flush(b_flush), .pkt_valid(b_pkt_valid), .pkt_ready(b_pkt_ready),
    .pkt_data(b_pkt_data), .pkt_len(b_pkt_len), .pkt_sum(b_pkt_sum),
    .pkt_count(b_pkt_count), .drop_count(b_drop_count), .overflow(b_overflow)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  len;
    logic [15:0] sum;
  } exp_pkt_t;

  exp_pkt_t exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] d);
    a_in_valid = 1'b1;
    a_in_data  = d;
    step();
    a_in_valid = 1'b0;
  endtask

  // Scoreboard: pop one expected package per observed handshake.
  always @(negedge clk) begin
    if (!reset && a_pkt_valid && a_pkt_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pkt", 64'd1, 64'd0);
      end else begin
        exp_pkt_t e;
        e = exp_q.pop_front();
        chk("pkt_data", 64'(a_pkt_data), 64'(e.data));
        chk("pkt_len",  64'(a_pkt_len),  64'(e.len));
        chk("pkt_sum",  64'(a_pkt_sum),  64'(e.sum));
      end
    end
  end

  initial begin
    logic [15:0] s;
    step();
    step();
    chk("rst_valid", 64'(a_pkt_valid), 64'd0);
    chk("rst_data",  64'(a_pkt_data),  64'd0);
    chk("rst_len",   64'(a_pkt_len),   64'd0);
    chk("rst_sum",   64'(a_pkt_sum),   64'd0);
    chk("rst_count", 64'(a_pkt_count), 64'd0);
    chk("rst_drop",  64'(a_drop_count), 64'd0);
    chk("rst_ovf",   64'(a_overflow),  64'd0);
    reset = 1'b0;
    step();

    // Full package, consumer always ready
    exp_q.push_back('{32'h04030201, 3'd4, 16'h000A});
    send_a(8'h01); send_a(8'h02); send_a(8'h03); send_a(8'h04);
    chk("full_valid_lat", 64'(a_pkt_valid), 64'd1);
    step();
    chk("full_count", 64'(a_pkt_count), 64'd1);
    chk("full_valid_fall", 64'(a_pkt_valid), 64'd0);

    // Partial package by flush
    exp_q.push_back('{32'h00FFFFFF, 3'd3, 16'h02FD});
    send_a(8'hFF); send_a(8'hFF); send_a(8'hFF);
    a_flush = 1'b1; step(); a_flush = 1'b0;
    chk("flush_valid", 64'(a_pkt_valid), 64'd1);
    step();
    chk("flush_count", 64'(a_pkt_count), 64'd2);

    // Flush at idx 0 is ignored; flush with the final beat gives one package
    a_flush = 1'b1; step(); a_flush = 1'b0;
    chk("flush_idx0", 64'(a_pkt_valid), 64'd0);
    exp_q.push_back('{32'h08070605, 3'd4, 16'h001A});
    send_a(8'h05); send_a(8'h06); send_a(8'h07);
    a_flush = 1'b1; send_a(8'h08); a_flush = 1'b0;
    chk("flush_last_valid", 64'(a_pkt_valid), 64'd1);
    step();
    step();
    chk("flush_last_single", 64'(a_pkt_valid), 64'd0);
    chk("flush_last_count", 64'(a_pkt_count), 64'd3);

    // Backpressure: drops while holding, then handshake beat carried over
    a_pkt_ready = 1'b0;
    exp_q.push_back('{32'h44332211, 3'd4, 16'h00AA});
    send_a(8'h11); send_a(8'h22); send_a(8'h33); send_a(8'h44);
    a_in_valid = 1'b1;
    a_in_data  = 8'h55;
    for (int i = 0; i < 5; i++) step();
    chk("hold_data", 64'(a_pkt_data), 64'h44332211);
    chk("hold_drop", 64'(a_drop_count), 64'd5);
    chk("hold_ovf", 64'(a_overflow), 64'd1);
    exp_q.push_back('{32'hAA998877, 3'd4, 16'h0242});
    a_pkt_ready = 1'b1;
    send_a(8'h77);
    chk("carry_count", 64'(a_pkt_count), 64'd4);
    send_a(8'h88); send_a(8'h99); send_a(8'hAA);
    step();
    chk("carry_drop", 64'(a_drop_count), 64'd5);
    chk("carry_count2", 64'(a_pkt_count), 64'd5);

    // Reset mid-package discards it
    send_a(8'h01); send_a(8'h02);
    reset = 1'b1; step(); reset = 1'b0;
    chk("mid_rst_count", 64'(a_pkt_count), 64'd0);
    chk("mid_rst_ovf", 64'(a_overflow), 64'd0);
    exp_q.push_back('{32'h40302010, 3'd4, 16'h00A0});
    send_a(8'h10); send_a(8'h20); send_a(8'h30); send_a(8'h40);
    step();
    chk("post_rst_count", 64'(a_pkt_count), 64'd1);
    chk("post_rst_drop", 64'(a_drop_count), 64'd0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    // NUM=100: all-FF package, then 300 more packages
    b_in_valid = 1'b1;
    b_in_data  = 8'hFF;
    for (int i = 0; i < 100; i++) step();
    b_in_valid = 1'b0;
    chk("b_valid", 64'(b_pkt_valid), 64'd1);
    chk("b_sum_ff", 64'(b_pkt_sum), 64'h639C);
    chk("b_len_ff", 64'(b_pkt_len), 64'd100);
    chk("b_top_slot", 64'(b_pkt_data[799:792]), 64'hFF);
    step();
    for (int p = 1; p <= 300; p++) begin
      b_in_valid = 1'b1;
      b_in_data  = 8'(p);
      for (int i = 0; i < 100; i++) step();
      b_in_valid = 1'b0;
      s = 16'(100 * (p % 256));
      chk("b_sum", 64'(b_pkt_sum), 64'(s));
      chk("b_len", 64'(b_pkt_len), 64'd100);
      step();
    end
    chk("b_count", 64'(b_pkt_count), 64'd301);
    chk("b_drop", 64'(b_drop_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
